// File: rtl/morse_pkg.sv
// Shared types and helpers for the Morse transmit engine.
package morse_pkg;

    typedef enum logic [1:0] {IDLE, MARK, GAP, DONE} morse_state_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    function automatic int unit_cnt_w(input int dash_units, input int gap_units);
        int m;
        m = (dash_units > gap_units) ? dash_units : gap_units;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/morse_tx_engine_if.sv
// Character request/status bundle between the letter decoder and the Morse engine.
interface morse_tx_engine_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) ();
    logic               start_i;
    logic               abort_i;
    logic [MAX_LEN-1:0] code_i;
    logic [LEN_W-1:0]   len_i;
    logic               busy_o;
    logic               tone_o;
    logic               dot_o;
    logic               dash_o;
    logic               done_o;

    modport master (output start_i, abort_i, code_i, len_i,
                    input  busy_o, tone_o, dot_o, dash_o, done_o);
    modport slave  (input  start_i, abort_i, code_i, len_i,
                    output busy_o, tone_o, dot_o, dash_o, done_o);
endinterface

// File: rtl/morse_unit_timer.sv
// Free-running unit timer: one-cycle unit_tick every TICKS_PER_UNIT enabled cycles.
module morse_unit_timer #(
    parameter int TICKS_PER_UNIT = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic unit_tick_o
);
    localparam int CNT_W = $clog2(TICKS_PER_UNIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign unit_tick_o = enable_i && (cnt_q == CNT_W'(TICKS_PER_UNIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || unit_tick_o)
            cnt_d = '0;
        else if (enable_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/morse_tx_engine.sv
// Serialises an LSB-first dot/dash pattern into timed marks and gaps.
// Outputs are registered; start is only honoured in IDLE or DONE.
module morse_tx_engine
    import morse_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 25_000_000,
    parameter int MAX_LEN        = 8,
    parameter int DASH_UNITS     = 3,
    parameter int GAP_UNITS      = 1,
    parameter int LEN_W          = $clog2(MAX_LEN + 1)
) (
    input  logic             CLOCK50_i,
    input  logic             reset_i,
    morse_tx_engine_if.slave bus
);
    localparam int UNIT_W = unit_cnt_w(DASH_UNITS, GAP_UNITS);

    morse_state_e       state_q;
    logic [MAX_LEN-1:0] sh_q;
    logic [LEN_W-1:0]   len_q, sym_q;
    logic [UNIT_W-1:0]  units_q;
    logic               busy_q, tone_q, dot_q, dash_q, done_q;

    logic               unit_tick, accept, phase_end, last_sym, timer_en;
    logic [LEN_W-1:0]   len_sat;
    logic [UNIT_W-1:0]  req_units;

    assign len_sat   = (bus.len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len_i;
    assign accept    = (state_q == IDLE || state_q == DONE) && bus.start_i && !bus.abort_i;
    assign timer_en  = (state_q == MARK) || (state_q == GAP);
    assign req_units = (state_q == MARK)
                     ? ((sh_q[0] == SYM_DASH) ? UNIT_W'(DASH_UNITS) : UNIT_W'(1))
                     : UNIT_W'(GAP_UNITS);
    assign phase_end = unit_tick && (units_q == req_units - UNIT_W'(1));
    assign last_sym  = (sym_q + LEN_W'(1)) == len_q;

    // Timer restarts on every state entry so each phase is whole units.
    morse_unit_timer #(.TICKS_PER_UNIT(TICKS_PER_UNIT)) u_timer (
        .clk_i      (CLOCK50_i),
        .rst_i      (reset_i),
        .clear_i    (bus.abort_i || accept || phase_end),
        .enable_i   (timer_en),
        .unit_tick_o(unit_tick)
    );

    always_ff @(posedge CLOCK50_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            len_q   <= '0;
            sym_q   <= '0;
            units_q <= '0;
            busy_q  <= 1'b0;
            tone_q  <= 1'b0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.abort_i) begin
            state_q <= IDLE;
            units_q <= '0;
            busy_q  <= 1'b0;
            tone_q  <= 1'b0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        sh_q    <= bus.code_i;
                        len_q   <= len_sat;
                        sym_q   <= '0;
                        units_q <= '0;
                        if (len_sat == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= MARK;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            tone_q  <= 1'b1;
                            dot_q   <= (bus.code_i[0] == SYM_DOT);
                            dash_q  <= (bus.code_i[0] == SYM_DASH);
                        end
                    end
                end
                MARK: begin
                    if (phase_end) begin
                        units_q <= '0;
                        tone_q  <= 1'b0;
                        dot_q   <= 1'b0;
                        dash_q  <= 1'b0;
                        if (last_sym) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= GAP;
                            sh_q    <= sh_q >> 1;
                            sym_q   <= sym_q + LEN_W'(1);
                        end
                    end else if (unit_tick) begin
                        units_q <= units_q + UNIT_W'(1);
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        state_q <= MARK;
                        units_q <= '0;
                        tone_q  <= 1'b1;
                        dot_q   <= (sh_q[0] == SYM_DOT);
                        dash_q  <= (sh_q[0] == SYM_DASH);
                    end else if (unit_tick) begin
                        units_q <= units_q + UNIT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.tone_o = tone_q;
    assign bus.dot_o  = dot_q;
    assign bus.dash_o = dash_q;
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_morse_tx_engine.sv
// Randomised and directed checks of morse_tx_engine against a waveform-level model.
module tb_morse_tx_engine;
    localparam int T    = 4;
    localparam int ML   = 8;
    localparam int DU   = 3;
    localparam int GU   = 1;
    localparam int LW   = $clog2(ML + 1);

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Expected per-cycle vector {busy, tone, dot, dash, done}
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    morse_tx_engine_if #(.MAX_LEN(ML)) bus ();

    morse_tx_engine #(
        .TICKS_PER_UNIT(T), .MAX_LEN(ML), .DASH_UNITS(DU), .GAP_UNITS(GU)
    ) dut (
        .CLOCK50_i(clk),
        .reset_i  (rst),
        .bus      (bus)
    );

    function automatic logic [4:0] obs();
        return {bus.busy_o, bus.tone_o, bus.dot_o, bus.dash_o, bus.done_o};
    endfunction

    task automatic build_model(input logic [ML-1:0] code, input int len);
        int n;
        exp_q.delete();
        n = (len > ML) ? ML : len;
        for (int s = 0; s < n; s++) begin
            int u;
            u = code[s] ? DU : 1;
            repeat (u * T) exp_q.push_back({1'b1, 1'b1, !code[s], code[s], 1'b0});
            if (s < n - 1)
                repeat (GU * T) exp_q.push_back(5'b10000);
        end
        repeat (4) exp_q.push_back(5'b00001);
    endtask

    // Start a character at the next edge and check every following cycle;
    // an extra start with a random pattern is pulsed at cycle pulse_at (0 = none).
    task automatic run_char(input string name, input logic [ML-1:0] code,
                            input int len, input int pulse_at);
        build_model(code, len);
        @(negedge clk);
        bus.code_i  = code;
        bus.len_i   = LW'(len);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.code_i  = ML'($urandom);
        bus.len_i   = LW'($urandom_range(1, 15));
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs() !== exp_q[i]) begin
                bad++;
                $display("FAIL %s cycle %0d: got %b want %b", name, i + 1, obs(), exp_q[i]);
            end
            total++;
            if ((bus.dot_o & bus.dash_o) !== 1'b0 || bus.tone_o !== (bus.dot_o | bus.dash_o)) begin
                bad++;
                $display("FAIL %s_excl cycle %0d: tone/dot/dash %b%b%b", name, i + 1,
                         bus.tone_o, bus.dot_o, bus.dash_o);
            end
            bus.start_i = (pulse_at != 0) && (i + 1 == pulse_at);
            @(negedge clk);
        end
        bus.start_i = 1'b0;
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            total++;
            if (obs() !== 5'b00000) begin
                bad++;
                $display("FAIL %s +%0d: got %b want 00000", name, i, obs());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.code_i  = '0;
        bus.len_i   = '0;
        repeat (3) @(negedge clk);
        total++;
        if (obs() !== 5'b00000) begin
            bad++;
            $display("FAIL reset: got %b want 00000", obs());
        end
        rst = 1'b0;
        @(negedge clk);
        expect_idle("post_reset", 3);
    endtask

    task automatic test_letters();
        run_char("E", 8'h00, 1, 0);
        run_char("A", 8'b10, 2, 0);
        run_char("len0", 8'hFF, 0, 0);
        run_char("len15", 8'hFF, 15, 0);
        total++;
        if (exp_q.size() - 4 != 124) begin
            bad++;
            $display("FAIL len15_len: got %0d want 124", exp_q.size() - 4);
        end
    endtask

    task automatic test_back_to_back();
        run_char("b2b_E", 8'h00, 1, 0);
        run_char("b2b_A_pulse", 8'b10, 2, 6);
        run_char("b2b_len0", 8'h3C, 0, 0);
        run_char("b2b_dash", 8'h01, 1, 3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic [ML-1:0] c;
            int l, p;
            c = ML'($urandom);
            l = $urandom_range(0, 15);
            p = (l > 0) ? $urandom_range(0, 3) : 0;
            run_char($sformatf("rand%0d", k), c, l, p);
        end
    endtask

    task automatic test_abort();
        build_model(8'b10, 2);
        @(negedge clk);
        bus.code_i  = 8'b10;
        bus.len_i   = LW'(2);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (obs() !== exp_q[i]) begin
                bad++;
                $display("FAIL abort_pre cycle %0d: got %b want %b", i + 1, obs(), exp_q[i]);
            end
            if (i == 9) bus.abort_i = 1'b1;
            @(negedge clk);
        end
        bus.abort_i = 1'b0;
        expect_idle("abort", 6);

        // Reset mid-mark: outputs must drop without waiting for an edge.
        @(negedge clk);
        bus.code_i  = 8'h01;
        bus.len_i   = LW'(1);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== 5'b11010) begin
            bad++;
            $display("FAIL rst_pre: got %b want 11010", obs());
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs() !== 5'b00000) begin
            bad++;
            $display("FAIL rst_async: got %b want 00000", obs());
        end
        @(negedge clk);
        rst = 1'b0;
        expect_idle("rst_mid", 16);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_letters();
        test_back_to_back();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/morse_tx_engine.md
Name: morse_tx_engine

Overview:
- Parametrised successor to the fixed 3-switch Morse letter path: serialises an arbitrary dot/dash pattern of up to MAX_LEN symbols.
- Symbol timing is in programmable time units, with a gap between symbols and a start/busy/done handshake.
- Replaces the separate half-second counter and fixed-length FSM. It sits between a letter decoder (supplies code_i/len_i) and the board LEDs.

Parameters:
- TICKS_PER_UNIT, 25_000_000, clock cycles per Morse time unit (0.5 s at 50 MHz); must be >= 2.
- MAX_LEN, 8, maximum symbols per character.
- DASH_UNITS, 3, dash duration in units.
- GAP_UNITS, 1, inter-symbol gap duration in units (>= 1).
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived).

Ports:
- CLOCK50_i  in  1  system clock, single clock domain.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request to transmit; sampled every cycle, acted on only in IDLE or DONE.
- abort_i  in  1  synchronous abort; returns to IDLE.
- code_i  in  MAX_LEN  symbol pattern, LSB first; 1 = dash, 0 = dot.
- len_i  in  LEN_W  number of valid symbols.
- busy_o  out  1  high while transmitting (MARK or GAP).
- tone_o  out  1  high during any mark.
- dot_o  out  1  high during a dot mark.
- dash_o  out  1  high during a dash mark.
- done_o  out  1  level; high after a completed character until the next accepted start or an abort.

Behaviour:
- Reset: asynchronous, active-high. State = IDLE; all outputs 0; shift register, symbol counter and timer = 0.
- States: IDLE, MARK, GAP, DONE.
- Start acceptance (IDLE or DONE, start_i=1, abort_i=0):
  - Latch code_i into the shift register and set len = min(len_i, MAX_LEN).
  - Clear done_o and restart the timer.
  - If len = 0: go to DONE and raise done_o the next cycle; no tone.
  - Otherwise go to MARK.
- start_i while busy is ignored; code_i/len_i are not re-sampled.
- MARK:
  - Mark length = 1 unit if the current bit is 0, DASH_UNITS units if 1.
  - tone_o = 1 for exactly (units × TICKS_PER_UNIT) cycles, starting the cycle after acceptance.
  - dot_o / dash_o mirror the current bit with tone_o.
  - At the end of the mark:
    - If symbols remain: shift the register right, increment the symbol count, go to GAP.
    - If this was the last symbol: go to DONE.
- GAP: all tone outputs 0 for GAP_UNITS × TICKS_PER_UNIT cycles, then MARK. There is no gap after the last symbol.
- DONE: done_o = 1 and busy_o = 0. Stays in DONE until start or abort.
- busy_o = 1 in MARK and GAP only.
- Timer:
  - Counts 0..TICKS_PER_UNIT-1, then wraps and emits a one-cycle unit_tick.
  - A unit counter compares completed units against the required length.
  - Both the timer and the unit counter reset on every state entry, so each phase is exact and never partial.
- abort_i has priority over start_i and over all transitions. Next cycle: IDLE, all outputs 0, done_o = 0.
- Reset mid-operation: outputs drop immediately (asynchronously); no done.
- Output encoding: outputs are registered (Moore). dot_o & dash_o never both 1; tone_o = dot_o | dash_o.
- Width rule: the symbol counter is LEN_W bits. Comparison uses the saturated len, so len_i > MAX_LEN transmits MAX_LEN symbols.

Decomposition:
- morse_pkg:
  - state enum morse_state_e {IDLE, MARK, GAP, DONE};
  - symbol constants SYM_DOT = 0, SYM_DASH = 1;
  - localparam helper for the unit-counter width, $clog2(max(DASH_UNITS, GAP_UNITS) + 1).
- One sub-module, morse_unit_timer:
  - parameterised by TICKS_PER_UNIT;
  - inputs clear and enable;
  - output unit_tick.
- The FSM, shift register and unit counter live in morse_tx_engine.

Test Plan:
All scenarios use TICKS_PER_UNIT=4, MAX_LEN=8, DASH_UNITS=3, GAP_UNITS=1. Start is accepted at edge 0.
1. "E": code=0, len=1 → tone_o and dot_o high for cycles 1–4; done_o high from cycle 5; busy_o high for cycles 1–4.
2. "A": code=8'b10, len=2 → dot at cycles 1–4, gap 5–8, dash (dash_o) at 9–20; done_o at 21; dash_o never overlaps dot_o.
3. len=0 → no tone; done_o=1 at cycle 1; busy_o stays 0.
4. len_i=15 with code=8'hFF → exactly 8 dashes (each 12 cycles) separated by 7 gaps (each 4 cycles); done_o at cycle 1+96+28=125.
5. start_i pulsed at cycle 6 during "A" → ignored; timing identical to scenario 2. A new start in DONE clears done_o the next cycle and retransmits.
6. abort_i at cycle 10 of "A", and separately reset_i asserted mid-mark → all outputs 0 (reset: same cycle; abort: next edge); state IDLE; done_o stays 0.
